// File: rtl/alu_seq_micro_if.sv
// Request/response bundle between the register-file read ports, the sequential
// micro ALU and the write-back/flag register.
interface alu_seq_micro_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Rx;
  logic [WIDTH-1:0] Ry;
  logic [3:0]       Sel_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] R0;
  logic [3:0]       Ban;
  logic             err;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, Rx, Ry, Sel_op, out_ready,
    input  in_ready, out_valid, R0, Ban, err
  );

  // The ALU itself.
  modport slave (
    input  in_valid, Rx, Ry, Sel_op, out_ready,
    output in_ready, out_valid, R0, Ban, err
  );
endinterface

// File: rtl/alu_seq_micro.sv
// Sequential micro ALU: single-cycle logic/add/sub, bit-serial shifts and an
// iterative shift-add multiplier behind a valid/ready handshake.
module alu_seq_micro #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst_n,
  alu_seq_micro_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SHL = 4'd2,
    OP_SHR = 4'd3,
    OP_NOT = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  localparam logic [WIDTH-1:0] WIDTH_OPND = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   WIDTH_CNT  = SHW'(WIDTH);
  localparam logic [SHW-1:0]   LAST_STEP  = SHW'(1);

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SHW-1:0]     cnt_q;

  // Flag packing shared by every opcode: {V, N, C, Z}.
  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {v, r[WIDTH-1], c, ~|r};
  endfunction

  // ---------------------------------------------------------------------------
  // Operand decode and single-cycle results, taken straight from the inputs.
  // ---------------------------------------------------------------------------
  logic             accept;
  logic [SHW-1:0]   k_in;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             is_shift;
  logic             is_multi;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic             imm_err;

  assign accept   = bus.in_valid & bus.in_ready;
  assign k_in     = (bus.Ry > WIDTH_OPND) ? WIDTH_CNT : bus.Ry[SHW-1:0];
  assign sum_w    = {1'b0, bus.Rx} + {1'b0, bus.Ry};
  assign diff_w   = {1'b0, bus.Rx} - {1'b0, bus.Ry};
  assign is_shift = (bus.Sel_op == OP_SHL) || (bus.Sel_op == OP_SHR);
  assign is_multi = (bus.Sel_op == OP_MUL) || (is_shift && (k_in != '0));

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    imm_err = 1'b0;
    case (bus.Sel_op)
      OP_ADD: begin
        imm_res = sum_w[WIDTH-1:0];
        imm_c   = sum_w[WIDTH];
        imm_v   = (bus.Rx[WIDTH-1] == bus.Ry[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != bus.Rx[WIDTH-1]);
      end
      OP_SUB: begin
        imm_res = diff_w[WIDTH-1:0];
        imm_c   = diff_w[WIDTH];
        imm_v   = (bus.Rx[WIDTH-1] != bus.Ry[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != bus.Rx[WIDTH-1]);
      end
      // Only reached with a zero shift count; non-zero counts go through BUSY.
      OP_SHL, OP_SHR: imm_res = bus.Rx;
      OP_NOT: imm_res = ~bus.Rx;
      OP_AND: imm_res = bus.Rx & bus.Ry;
      OP_OR:  imm_res = bus.Rx | bus.Ry;
      OP_XOR: imm_res = bus.Rx ^ bus.Ry;
      OP_MUL: imm_res = '0;
      default: imm_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the multi-cycle operations and its would-be final value.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   sh_next;
  logic               sh_out_bit;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c;

  assign sh_next    = (op_q == OP_SHR) ? (sh_q >> 1) : (sh_q << 1);
  assign sh_out_bit = (op_q == OP_SHR) ? sh_q[0] : sh_q[WIDTH-1];
  assign acc_next   = acc_q + (mul_b_q[0] ? mcand_q : '0);

  always_comb begin
    fin_res = sh_next;
    fin_c   = sh_out_bit;
    if (op_q == OP_MUL) begin
      fin_res = acc_next[WIDTH-1:0];
      fin_c   = |acc_next[2*WIDTH-1:WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs.
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples values from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.R0        <= '0;
      bus.Ban       <= '0;
      bus.err       <= 1'b0;
      op_q          <= '0;
      sh_q          <= '0;
      mul_b_q       <= '0;
      mcand_q       <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            op_q         <= bus.Sel_op;
            if (is_multi) begin
              state   <= S_BUSY;
              sh_q    <= bus.Rx;
              mcand_q <= {{WIDTH{1'b0}}, bus.Rx};
              mul_b_q <= bus.Ry;
              acc_q   <= '0;
              cnt_q   <= (bus.Sel_op == OP_MUL) ? WIDTH_CNT : k_in;
            end else begin
              state         <= S_DONE;
              bus.out_valid <= 1'b1;
              bus.R0        <= imm_res;
              bus.Ban       <= flags_of(imm_res, imm_c, imm_v);
              bus.err       <= imm_err;
            end
          end
        end

        S_BUSY: begin
          sh_q    <= sh_next;
          mcand_q <= mcand_q << 1;
          mul_b_q <= mul_b_q >> 1;
          acc_q   <= acc_next;
          cnt_q   <= cnt_q - LAST_STEP;
          // Only the last step publishes; intermediate values never reach R0/Ban.
          if (cnt_q == LAST_STEP) begin
            state         <= S_DONE;
            bus.out_valid <= 1'b1;
            bus.R0        <= fin_res;
            bus.Ban       <= flags_of(fin_res, fin_c, 1'b0);
            bus.err       <= 1'b0;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_micro.sv
// Directed bench for alu_seq_micro (WIDTH=8): literal expectations per vector
// plus an arithmetic reference model checked every cycle a result is presented.
module tb_alu_seq_micro;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   transfers = 0;

  alu_seq_micro_if #(.WIDTH(W)) bus ();

  alu_seq_micro #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int ban;
    int err;
    int lat;
  } exp_t;

  exp_t exp_cur;
  logic exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference model: plain integer arithmetic on the opcode definitions.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   c, v, k, s, p;
    c = 0; v = 0; e.err = 0; e.lat = 1; e.res = 0;
    k = (b > W) ? W : b;
    case (op)
      0: begin s = a + b; e.res = s % 256; c = int'(s > 255);
               s = sgn(a) + sgn(b); v = int'(s > 127 || s < -128); end
      1: begin e.res = (a - b + 256) % 256; c = int'(a < b);
               s = sgn(a) - sgn(b); v = int'(s > 127 || s < -128); end
      2: begin e.res = (a << k) % 256; c = (k > 0) ? ((a << k) >> W) % 2 : 0; e.lat = 1 + k; end
      3: begin e.res = a >> k; c = (k > 0) ? (a >> (k - 1)) % 2 : 0; e.lat = 1 + k; end
      4: e.res = 255 - a;
      5: e.res = a & b;
      6: e.res = a | b;
      7: e.res = a ^ b;
      8: begin p = a * b; e.res = p % 256; c = int'(p > 255); e.lat = 1 + W; end
      default: e.err = 1;
    endcase
    e.ban = v * 8 + ((e.res >= 128) ? 4 : 0) + c * 2 + ((e.res == 0) ? 1 : 0);
    return e;
  endfunction

  // Compare process: whenever a result is presented it must match the model.
  initial forever begin
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      if (!exp_valid) begin
        check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("model_R0",  32'(bus.R0),  32'(exp_cur.res));
        check("model_Ban", 32'(bus.Ban), 32'(exp_cur.ban));
        check("model_err", 32'(bus.err), 32'(exp_cur.err));
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) transfers++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op, check latency and literal results, optionally hold off the
  // consumer for 'hold' cycles while poking in_valid, then complete the transfer.
  task automatic run_op(input string name, input int op, input int a, input int b,
                        input int res, input int ban, input int errv, input int lat,
                        input int hold);
    int cycles;
    int t0;
    exp_t m;
    m = model(op, a, b);
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({name, "_model_lat"}, 32'(m.lat), 32'(lat));
    bus.out_ready = (hold == 0);
    bus.Sel_op    = 4'(op);
    bus.Rx        = 8'(a);
    bus.Ry        = 8'(b);
    bus.in_valid  = 1'b1;
    exp_cur       = m;
    exp_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cycles = 1;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, "_latency"}, 32'(cycles), 32'(lat));
    check({name, "_R0"},  32'(bus.R0),  32'(res));
    check({name, "_Ban"}, 32'(bus.Ban), 32'(ban));
    check({name, "_err"}, 32'(bus.err), 32'(errv));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.Sel_op   = 4'd0;
      bus.Rx       = 8'hFF;
      bus.Ry       = 8'(i);
      check({name, "_bp_in_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check({name, "_bp_out_valid"}, 32'(bus.out_valid), 32'd1);
    end
    t0 = transfers;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b0;
    check({name, "_transfers"}, 32'(transfers - t0), 32'd1);
    check({name, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    check({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.Rx        = '0;
    bus.Ry        = '0;
    bus.Sel_op    = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_R0",        32'(bus.R0),        32'd0);
    check("rst_Ban",       32'(bus.Ban),       32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //       name        op  Rx    Ry    R0    Ban  err lat hold
    run_op("add_ff_01",  0, 'hFF, 'h01, 'h00, 'h3, 0, 1, 0);
    run_op("add_7f_01",  0, 'h7F, 'h01, 'h80, 'hC, 0, 1, 0);
    run_op("sub_05_07",  1, 'h05, 'h07, 'hFE, 'h6, 0, 1, 0);
    run_op("sub_80_01",  1, 'h80, 'h01, 'h7F, 'h8, 0, 1, 0);
    run_op("shl_81_3",   2, 'h81, 3,    'h08, 'h0, 0, 4, 0);
    run_op("shr_81_1",   3, 'h81, 1,    'h40, 'h2, 0, 2, 0);
    run_op("shl_01_20",  2, 'h01, 20,   'h00, 'h3, 0, 9, 0);
    run_op("shl_a5_0",   2, 'hA5, 0,    'hA5, 'h4, 0, 1, 0);
    run_op("shr_f0_4",   3, 'hF0, 4,    'h0F, 'h0, 0, 5, 0);
    run_op("shr_80_8",   3, 'h80, 8,    'h00, 'h3, 0, 9, 0);
    run_op("not_00",     4, 'h00, 'h00, 'hFF, 'h4, 0, 1, 0);
    run_op("and_a5_0f",  5, 'hA5, 'h0F, 'h05, 'h0, 0, 1, 0);
    run_op("or_a5_0f",   6, 'hA5, 'h0F, 'hAF, 'h4, 0, 1, 0);
    run_op("xor_a5_a5",  7, 'hA5, 'hA5, 'h00, 'h1, 0, 1, 0);
    run_op("mul_10_11",  8, 'h10, 'h11, 'h10, 'h2, 0, 9, 0);
    run_op("mul_0f_03",  8, 'h0F, 'h03, 'h2D, 'h0, 0, 9, 0);
    run_op("mul_ff_ff",  8, 'hFF, 'hFF, 'h01, 'h2, 0, 9, 0);
    run_op("illegal_12", 12, 'h55, 'h33, 'h00, 'h1, 1, 1, 0);
    run_op("bp_add_3_4", 0, 'h03, 'h04, 'h07, 'h0, 0, 1, 5);
    run_op("bp_shl_3_2", 2, 'h03, 2,    'h0C, 'h0, 0, 3, 3);

    // Ignored in_valid pulses during backpressure must not have started anything.
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_bp", 32'(bus.out_valid), 32'd0);

    // Reset while a multiply is in flight: aborted, no result ever appears.
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    bus.Sel_op   = 4'd8;
    bus.Rx       = 8'h10;
    bus.Ry       = 8'h11;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready1", 32'(bus.in_ready),  32'd1);
    check("abort_R0",        32'(bus.R0),        32'd0);
    check("abort_Ban",       32'(bus.Ban),       32'd0);
    check("abort_err",       32'(bus.err),       32'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_result", 32'(bus.out_valid), 32'd0);

    run_op("post_abort_sub", 1, 'h00, 'h01, 'hFF, 'h6, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
